// File: rtl/mem_if_responder.sv
// -----------------------------------------------------------------------------
// mem_if_responder
//   Single-port 64-bit memory model that answers a simple req/gnt core
//   interface. Each request is captured in IDLE, held for a programmable
//   number of wait states (extendable with stall) and answered with a
//   one-cycle grant. Writes honour per-byte strobes. Accesses outside the
//   mapped window are answered with an error. A requester that changes its
//   request while it is waiting is flagged and the transaction is dropped.
//
// Parameters
//   BASE_ADDR   : byte address of memory word 0
//   DEPTH       : number of 64-bit words (power of two, >= 2)
//   WAIT_CYCLES : fixed wait states before grant (0..15)
//
// Ports
//   clock      in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high
//   mem_req    in   1  request from core
//   mem_addr   in  64  request byte address
//   mem_wen    in   1  write enable
//   mem_strb   in   8  byte write strobes
//   mem_wdata  in  64  write data
//   stall      in   1  extra wait-state injection
//   mem_gnt    out  1  response valid, one-cycle pulse
//   mem_err    out  1  response error, valid with mem_gnt
//   mem_rdata  out 64  read data, valid with mem_gnt
//   proto_err  out  1  sticky requester protocol-violation flag
// -----------------------------------------------------------------------------
module mem_if_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic        mem_wen,
    input  logic [7:0]  mem_strb,
    input  logic [63:0] mem_wdata,
    input  logic        stall,
    output logic        mem_gnt,
    output logic        mem_err,
    output logic [63:0] mem_rdata,
    output logic        proto_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [7:0]  strb_q, strb_d;
    logic [63:0] wdata_q, wdata_d;
    logic        proto_err_q, proto_err_d;

    logic [63:0] mem_q [DEPTH];
    logic        mem_we;

    // ------------------------------------------------------------------
    // Address decode on the captured address. The offset comparison is
    // done after subtracting the base so that a window ending at the top
    // of the 64-bit space cannot wrap and alias low addresses.
    // ------------------------------------------------------------------
    logic [63:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;

    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
    assign word_idx = offset[IDX_W+2:3];

    // While waiting, the requester must keep presenting the same request.
    logic req_match;
    assign req_match = mem_req
                    && (mem_addr  == addr_q)
                    && (mem_wen   == wen_q)
                    && (mem_strb  == strb_q)
                    && (mem_wdata == wdata_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    wen_d   = mem_wen;
                    strb_d  = mem_strb;
                    wdata_d = mem_wdata;
                    cnt_d   = WAIT_CNT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A violation takes priority over completing the wait.
                if (!req_match) begin
                    proto_err_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = S_IDLE;
                end else if (stall) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // Request input is ignored here: a held req is not a new one.
                mem_we  = wen_q && in_range;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response outputs, driven only while in RESP
    // ------------------------------------------------------------------
    always_comb begin
        mem_gnt   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = 64'd0;
        if (state_q == S_RESP) begin
            mem_gnt = 1'b1;
            mem_err = !in_range;
            if (!wen_q && in_range) begin
                mem_rdata = mem_q[word_idx];
            end
        end
    end

    assign proto_err = proto_err_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 64'd0;
            wen_q       <= 1'b0;
            strb_q      <= 8'd0;
            wdata_q     <= 64'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset. A reset landing on the RESP cycle cancels the
    // write so an abandoned transaction never modifies memory.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 8; b++) begin
                if (strb_q[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_if_responder.sv
module tb_mem_if_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 16;
    localparam int          WAITC = 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH * 8);

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic        stall;
    logic        mem_gnt;
    logic        mem_err;
    logic [63:0] mem_rdata;
    logic        proto_err;

    mem_if_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wen  (mem_wen),
        .mem_strb (mem_strb),
        .mem_wdata(mem_wdata),
        .stall    (stall),
        .mem_gnt  (mem_gnt),
        .mem_err  (mem_err),
        .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    logic        proto_exp;
    logic [63:0] model [DEPTH];
    logic [63:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode: window membership using 65-bit sums so nothing wraps.
    function automatic logic ref_in_range(input logic [63:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, SPAN}));
    endfunction

    function automatic int ref_index(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    // One complete transaction, called at a negedge with the DUT in IDLE.
    // nstall = number of WAIT cycles during which stall is held high.
    task automatic txn(input logic [63:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] d, input int nstall);
        int          n;
        logic        got;
        logic        ok;
        logic [63:0] exp_rd;
        logic [63:0] mask;
        int          idx;
        mem_req = 1'b1; mem_addr = a; mem_wen = w; mem_strb = s; mem_wdata = d; stall = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clock); n++;
            @(negedge clock);
            if (mem_gnt) got = 1'b1;
            else stall = (n <= nstall);
        end
        stall = 1'b0;
        chk("gnt_seen", 64'(got), 64'd1);
        ok  = ref_in_range(a);
        idx = ok ? ref_index(a) : 0;
        exp_rd = (!w && ok) ? model[idx] : 64'd0;
        if (got) begin
            chk("latency", 64'(n), 64'(2 + WAITC + nstall));
            chk("err", 64'(mem_err), 64'(!ok));
            chk("rdata", mem_rdata, exp_rd);
            chk("proto_err", 64'(proto_err), 64'(proto_exp));
        end
        last_rdata = mem_rdata;
        last_err   = mem_err;
        if (w && ok) begin
            mask = 64'd0;
            for (int b = 0; b < 8; b++) if (s[b]) mask = mask | (64'hFF << (8 * b));
            model[idx] = (model[idx] & ~mask) | (d & mask);
        end
        // req stays high through the end of RESP; it must not start a new access.
        @(posedge clock);
        @(negedge clock);
        chk("gnt_pulse", 64'(mem_gnt), 64'd0);
        chk("idle_rdata", mem_rdata, 64'd0);
    endtask

    task automatic idle(input int n);
        mem_req = 1'b0; stall = 1'b0;
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            chk("idle_gnt", 64'(mem_gnt), 64'd0);
        end
    endtask

    // Protocol violation in WAIT: kind 0 drops req, kind 1 moves the address.
    task automatic viol(input int kind, input logic [63:0] a, input logic [63:0] d);
        mem_req = 1'b1; mem_addr = a; mem_wen = 1'b1; mem_strb = 8'hFF; mem_wdata = d; stall = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("viol_wait_gnt", 64'(mem_gnt), 64'd0);
        if (kind == 0) mem_req = 1'b0;
        else mem_addr = a ^ 64'h8;
        @(posedge clock);
        @(negedge clock);
        mem_req = 1'b0;
        proto_exp = 1'b1;
        chk("viol_proto", 64'(proto_err), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("viol_gnt", 64'(mem_gnt), 64'd0);
            chk("viol_sticky", 64'(proto_err), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        int          sel;
        reset = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_wen = 1'b0;
        mem_strb = '0; mem_wdata = '0; stall = 1'b0; proto_exp = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_gnt", 64'(mem_gnt), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        reset = 1'b0;

        // Fill every word so the model knows all contents.
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom, $urandom};
            txn(BASE + 64'(8 * i), 1'b1, 8'hFF, d, 0);
        end

        // Full write then read back.
        txn(BASE + 64'd8, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
        chk("wr_err", 64'(last_err), 64'd0);
        txn(BASE + 64'd8, 1'b0, 8'h00, 64'd0, 0);
        chk("rd_full", last_rdata, 64'h0123_4567_89AB_CDEF);
        // Partial strobe write.
        txn(BASE + 64'd8, 1'b1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        txn(BASE + 64'd8, 1'b0, 8'h00, 64'd0, 0);
        chk("rd_strb", last_rdata, 64'h0123_4567_FFFF_FFFF);
        // Zero strobe write leaves memory alone.
        txn(BASE + 64'd8, 1'b1, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        chk("strb0_err", 64'(last_err), 64'd0);
        txn(BASE + 64'd8 + 64'd5, 1'b0, 8'h00, 64'd0, 0);
        chk("rd_strb0", last_rdata, 64'h0123_4567_FFFF_FFFF);
        // Window boundaries.
        txn(BASE + SPAN, 1'b0, 8'h00, 64'd0, 0);
        chk("oor_err", 64'(last_err), 64'd1);
        txn(BASE + SPAN, 1'b1, 8'hFF, 64'h5555_5555_5555_5555, 0);
        txn(BASE + SPAN - 64'd8, 1'b0, 8'h00, 64'd0, 0);
        chk("last_word_err", 64'(last_err), 64'd0);
        txn(BASE - 64'd1, 1'b1, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 0);
        chk("below_err", 64'(last_err), 64'd1);
        txn(BASE, 1'b0, 8'h00, 64'd0, 0);
        // Stall extends the wait.
        txn(BASE + 64'd8, 1'b0, 8'h00, 64'd0, 5);
        idle(2);

        // Protocol violations, then normal traffic.
        viol(0, BASE + 64'd24, 64'h1111_2222_3333_4444);
        txn(BASE + 64'd24, 1'b0, 8'h00, 64'd0, 0);
        viol(1, BASE + 64'd32, 64'h9999_8888_7777_6666);
        txn(BASE + 64'd32, 1'b0, 8'h00, 64'd0, 0);
        txn(BASE + 64'd40, 1'b0, 8'h00, 64'd0, 0);

        // Reset while a write waits; req is still high at the reset edge.
        mem_req = 1'b1; mem_addr = BASE + 64'd40; mem_wen = 1'b1;
        mem_strb = 8'hFF; mem_wdata = 64'hCAFE_F00D_CAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; mem_req = 1'b0;
        proto_exp = 1'b0;
        chk("rstw_gnt", 64'(mem_gnt), 64'd0);
        chk("rstw_err", 64'(mem_err), 64'd0);
        chk("rstw_rdata", mem_rdata, 64'd0);
        chk("rstw_proto", 64'(proto_err), 64'd0);
        idle(4);
        txn(BASE + 64'd40, 1'b0, 8'h00, 64'd0, 0);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                6:       a = BASE + SPAN - 64'd8 + 64'($urandom_range(0, 7));
                7:       a = BASE + SPAN + 64'($urandom_range(0, 64));
                8:       a = BASE - 64'd1 - 64'($urandom_range(0, 64));
                9:       a = {$urandom, $urandom};
                default: a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
            endcase
            s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d = {$urandom, $urandom};
            txn(a, 1'($urandom), s, d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        // Final sweep of all words against the model.
        for (int i = 0; i < DEPTH; i++) txn(BASE + 64'(8 * i), 1'b0, 8'h00, 64'd0, 0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_if_responder.md
MEM_IF_RESPONDER -- requirements
Module: mem_if_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, meaning the byte address of the first memory word.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of 64-bit memory words (power of two, at least 2).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the fixed wait states before grant (0..15).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, synchronous active-high reset.
REQ-007 Port: mem_req, input, 1, request from the core.
REQ-008 Port: mem_addr, input, 64, request byte address.
REQ-009 Port: mem_wen, input, 1, write enable.
REQ-010 Port: mem_strb, input, 8, byte write strobes.
REQ-011 Port: mem_wdata, input, 64, write data.
REQ-012 Port: stall, input, 1, extra wait-state injection.
REQ-013 Port: mem_gnt, output, 1, response valid, one-cycle pulse.
REQ-014 Port: mem_err, output, 1, response error, valid with mem_gnt.
REQ-015 Port: mem_rdata, output, 64, read data, valid with mem_gnt.
REQ-016 Port: proto_err, output, 1, sticky requester protocol-violation flag.

Function
REQ-017 The block SHALL implement FSM states IDLE, WAIT and RESP, with a 4-bit wait counter.
REQ-018 In IDLE with mem_req=1, the block SHALL capture addr, wen, strb and wdata, load counter=WAIT_CYCLES and enter WAIT.
REQ-019 In WAIT with stall=1, the counter SHALL hold.
REQ-020 In WAIT with stall=0 and counter!=0, the counter SHALL decrement.
REQ-021 In WAIT with stall=0 and counter==0, the block SHALL enter RESP.
REQ-022 In RESP, mem_gnt SHALL be 1 for exactly one cycle and the next state SHALL be IDLE, regardless of mem_req.
REQ-023 Latency: with stall held at 0, a request first seen in IDLE at cycle t SHALL receive mem_gnt at cycle t+2+WAIT_CYCLES.
REQ-024 Back-to-back: the next request is sampled no earlier than the cycle after mem_gnt; a req held high through the gnt cycle SHALL NOT be treated as a new request.
REQ-025 Address decode: the captured address is in range iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH.
REQ-026 Word index SHALL be (addr-BASE_ADDR)>>3; addr[2:0] SHALL be ignored.
REQ-027 For an in-range read in RESP: mem_rdata = mem[index], mem_err=0.
REQ-028 For an in-range write, the block SHALL update only the bytes whose mem_strb bit is set, in the RESP cycle. mem_rdata = 0, mem_err = 0.
REQ-029 Write with strb=0 SHALL leave memory unchanged and still grant with mem_err=0.
REQ-030 For an out-of-range access, the block SHALL leave memory unchanged. mem_err = 1, mem_rdata = 0.
REQ-031 Outside RESP, mem_gnt, mem_err and mem_rdata SHALL be 0.
REQ-032 Protocol rule: in WAIT, mem_req must stay 1, and addr, wen, strb and wdata must equal the captured values.
REQ-033 On a protocol-rule violation, the block SHALL set proto_err (sticky until reset), abort to IDLE, make no memory update and issue no mem_gnt.
REQ-034 A request immediately following an abort SHALL be handled normally from IDLE.
REQ-035 Boundary addresses: BASE_ADDR+8*DEPTH-8 SHALL be in range, and BASE_ADDR+8*DEPTH and BASE_ADDR-1 SHALL be out of range. Address arithmetic is 64-bit with no wrap-around aliasing.
REQ-036 Expected RTL size: roughly 150-250 lines.

Reset
REQ-037 When reset=1 at a clock edge, the block SHALL enter IDLE and clear the counter. mem_gnt, mem_err, mem_rdata and proto_err SHALL be 0.
REQ-038 Reset asserted in WAIT or RESP SHALL abandon the transaction with no memory write and no gnt in the following cycle.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 When reset and mem_req are both 1 in the same cycle, reset SHALL win and the request SHALL be ignored.

Verification
REQ-041 Bench SHALL cover: WAIT_CYCLES=1, write addr=BASE_ADDR+8, strb=8'hFF, wdata=64'h0123_4567_89AB_CDEF at t=0 -> gnt=1 at t=3, err=0; read of same address -> rdata=64'h0123_4567_89AB_CDEF.
REQ-042 Bench SHALL cover: after REQ-041, write strb=8'h0F, wdata=64'hFFFF_FFFF_FFFF_FFFF -> subsequent read returns 64'h0123_4567_FFFF_FFFF.
REQ-043 Bench SHALL cover: read at BASE_ADDR+8*DEPTH -> gnt with err=1, rdata=0, memory unchanged; read at BASE_ADDR+8*DEPTH-8 -> err=0.
REQ-044 Bench SHALL cover: stall=1 for 5 cycles in WAIT with WAIT_CYCLES=1 -> gnt at t=8 instead of t=3.
REQ-045 Bench SHALL cover: mem_req dropped, or mem_addr changed, in WAIT -> no gnt, proto_err=1 and held, no memory write; next valid request is granted normally.
REQ-046 Bench SHALL cover: reset asserted in WAIT of a write -> all outputs 0 next cycle, and a read of the target address returns its old value.
